// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - MMIO offsets and address-region decode for dmem_responder
package dmem_pkg;

   localparam logic [31:0] OFF_TOHOST  = 32'h0000_0000;
   localparam logic [31:0] OFF_CYC_LO  = 32'h0000_0004;
   localparam logic [31:0] OFF_CYC_HI  = 32'h0000_0008;
   localparam logic [31:0] OFF_SCRATCH = 32'h0000_000C;

   typedef enum logic [2:0] {
      REG_RAM,
      REG_TOHOST,
      REG_CYC_LO,
      REG_CYC_HI,
      REG_SCRATCH,
      REG_UNMAPPED
   } region_t;

   // Decode on the word-aligned address so a misaligned access still names the
   // region it falls in; RAM takes priority if the MMIO window overlaps it.
   function automatic region_t decode_region(input logic [31:0] addr,
                                             input logic [31:0] mmio_base,
                                             input logic [31:0] ram_bytes);
      logic [31:0] word_addr;
      region_t     region;
      word_addr = {addr[31:2], 2'b00};
      region    = REG_UNMAPPED;
      if (word_addr < ram_bytes)
         region = REG_RAM;
      else if (word_addr == mmio_base + OFF_TOHOST)
         region = REG_TOHOST;
      else if (word_addr == mmio_base + OFF_CYC_LO)
         region = REG_CYC_LO;
      else if (word_addr == mmio_base + OFF_CYC_HI)
         region = REG_CYC_HI;
      else if (word_addr == mmio_base + OFF_SCRATCH)
         region = REG_SCRATCH;
      return region;
   endfunction

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - word RAM with asynchronous read and synchronous write
module dmem_array #(
   parameter int RAM_WORDS = 64
) (
   input  logic                         clk,
   input  logic                         we,
   input  logic [$clog2(RAM_WORDS)-1:0] addr,
   input  logic [31:0]                  wdata,
   output logic [31:0]                  rdata
);

   logic [31:0] mem [RAM_WORDS];

   // Contents are deliberately not reset so a test image survives a CPU reset.
   always_ff @(posedge clk) begin
      if (we)
         mem[addr] <= wdata;
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - data-memory responder with RAM, TOHOST/SCRATCH MMIO and fault capture; optional DMEM_CYCLE_COUNTER_EN
module dmem_responder
   import dmem_pkg::*;
#(
   parameter int          RAM_WORDS   = 64,
   parameter logic [31:0] TOHOST_ADDR = 32'h8000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] memory_address,
   input  logic [31:0] memory_write,
   input  logic        memory_we,
   output logic [31:0] memory_out,
   output logic        halted,
   output logic [31:0] halt_code,
   output logic        fault,
   output logic [31:0] fault_addr
);

   localparam int          AW        = $clog2(RAM_WORDS);
   localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

   region_t     region;
   logic        misaligned;
   logic        mapped;
   logic        illegal;
   logic        wr_ok;
   logic        ram_we;
   logic [31:0] ram_rdata;
   logic [31:0] scratch;
   logic [31:0] cyc_lo;
   logic [31:0] cyc_hi;

   assign region     = decode_region(memory_address, TOHOST_ADDR, RAM_BYTES);
   assign misaligned = |memory_address[1:0];
   assign mapped     = (region != REG_UNMAPPED);

   // Misaligned writes are always illegal; misaligned reads only when mapped.
   // Unmapped and counter writes are illegal, unmapped reads just return 0.
   assign illegal = rst_n &
                    ((misaligned & (memory_we | mapped)) |
                     (memory_we & ((region == REG_UNMAPPED) ||
                                   (region == REG_CYC_LO)   ||
                                   (region == REG_CYC_HI))));

   assign wr_ok  = rst_n & memory_we & ~halted & ~illegal;
   assign ram_we = wr_ok & (region == REG_RAM);

   dmem_array #(
      .RAM_WORDS (RAM_WORDS)
   ) u_array (
      .clk   (clk),
      .we    (ram_we),
      .addr  (memory_address[AW+1:2]),
      .wdata (memory_write),
      .rdata (ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         halted     <= 1'b0;
         halt_code  <= 32'h0;
         fault      <= 1'b0;
         fault_addr <= 32'h0;
         scratch    <= 32'h0;
      end else begin
         if (wr_ok && (region == REG_TOHOST)) begin
            halted    <= 1'b1;
            halt_code <= memory_write;
         end
         if (wr_ok && (region == REG_SCRATCH))
            scratch <= memory_write;
         // Only the first offending address is kept for post-mortem.
         if (illegal && !fault) begin
            fault      <= 1'b1;
            fault_addr <= memory_address;
         end
      end
   end

`ifdef DMEM_CYCLE_COUNTER_EN
   logic [63:0] cycle_cnt;

   always_ff @(posedge clk) begin
      if (!rst_n)
         cycle_cnt <= 64'h0;
      else if (!halted)
         cycle_cnt <= cycle_cnt + 64'h1;
   end

   assign cyc_lo = cycle_cnt[31:0];
   assign cyc_hi = cycle_cnt[63:32];
`else
   assign cyc_lo = 32'h0;
   assign cyc_hi = 32'h0;
`endif

   always_comb begin
      memory_out = 32'h0;
      case (region)
         REG_RAM:     memory_out = ram_rdata;
         REG_TOHOST:  memory_out = halt_code;
         REG_CYC_LO:  memory_out = cyc_lo;
         REG_CYC_HI:  memory_out = cyc_hi;
         REG_SCRATCH: memory_out = scratch;
         default:     memory_out = 32'h0;
      endcase
   end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed scoreboard bench for dmem_responder
module tb_dmem_responder;

   localparam logic [31:0] TOHOST  = 32'h8000_0000;
   localparam logic [31:0] CYC_LO  = TOHOST + 32'h4;
   localparam logic [31:0] CYC_HI  = TOHOST + 32'h8;
   localparam logic [31:0] SCRATCH = TOHOST + 32'hC;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [31:0] memory_address = 32'h0;
   logic [31:0] memory_write = 32'h0;
   logic        memory_we = 1'b0;
   logic [31:0] memory_out;
   logic        halted;
   logic [31:0] halt_code;
   logic        fault;
   logic [31:0] fault_addr;

   int checks = 0;
   int failures = 0;
   logic [31:0] exp_q [$];

   logic [63:0] cyc_m = 64'h0;
   logic        halt_m = 1'b0;
   logic [31:0] frozen;

   dmem_responder #(
      .RAM_WORDS   (64),
      .TOHOST_ADDR (TOHOST)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .memory_address (memory_address),
      .memory_write   (memory_write),
      .memory_we      (memory_we),
      .memory_out     (memory_out),
      .halted         (halted),
      .halt_code      (halt_code),
      .fault          (fault),
      .fault_addr     (fault_addr)
   );

   always #5 clk = ~clk;

   // Reference cycle counter: counts enabled edges until the first TOHOST store.
   always @(posedge clk) begin
      if (!rst_n) begin
         cyc_m  = 64'h0;
         halt_m = 1'b0;
      end else if (!halt_m) begin
         cyc_m = cyc_m + 64'h1;
         if (memory_we && memory_address == TOHOST)
            halt_m = 1'b1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic rd(input logic [31:0] addr, input logic [31:0] exp, input string tag);
      logic [31:0] e;
      @(negedge clk);
      memory_address = addr;
      memory_we      = 1'b0;
      exp_q.push_back(exp);
      #1;
      e = exp_q.pop_front();
      chk(tag, memory_out, e);
   endtask

   task automatic wr(input logic [31:0] addr, input logic [31:0] data);
      @(negedge clk);
      memory_address = addr;
      memory_write   = data;
      memory_we      = 1'b1;
      @(posedge clk);
      #1 memory_we = 1'b0;
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_halted", {31'h0, halted}, 32'h0);
      chk("rst_halt_code", halt_code, 32'h0);
      chk("rst_fault", {31'h0, fault}, 32'h0);
      chk("rst_fault_addr", fault_addr, 32'h0);
      rd(SCRATCH, 32'h0, "rst_scratch");

      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) @(posedge clk);
`ifdef DMEM_CYCLE_COUNTER_EN
      rd(CYC_LO, 32'd20, "cycle_lo_20");
`else
      rd(CYC_LO, 32'h0, "cycle_lo_absent");
`endif
      rd(CYC_HI, 32'h0, "cycle_hi");

      wr(32'h0, 32'd10);
      wr(32'h4, 32'd7);
      wr(32'h8, 32'h22);
      @(negedge clk);
      memory_address = 32'h4;
      memory_write   = 32'd10;
      memory_we      = 1'b1;
      exp_q.push_back(32'd7);
      #1 chk("same_cycle_old", memory_out, exp_q.pop_front());
      @(posedge clk);
      #1 memory_we = 1'b0;
      rd(32'h4, 32'd10, "ram_w1_new");
      rd(32'h0, 32'd10, "ram_w0");

      wr(32'h6, 32'h99);
      chk("misalign_fault", {31'h0, fault}, 32'h1);
      chk("misalign_fault_addr", fault_addr, 32'h6);
      rd(32'h4, 32'd10, "misalign_no_store");
      wr(32'h4000_0000, 32'h55);
      chk("fault_addr_sticky", fault_addr, 32'h6);

      @(negedge clk);
      rst_n          = 1'b0;
      memory_address = 32'h8;
      memory_write   = 32'hBAD;
      memory_we      = 1'b1;
      @(posedge clk);
      #1;
      memory_we = 1'b0;
      rst_n     = 1'b1;
      rd(32'h8, 32'h22, "reset_drops_write");
      chk("reset_fault_clr", {31'h0, fault}, 32'h0);
      chk("reset_fault_addr_clr", fault_addr, 32'h0);
      chk("reset_halted_clr", {31'h0, halted}, 32'h0);

      rd(32'h4000_0000, 32'h0, "unmapped_read");
      chk("unmapped_read_no_fault", {31'h0, fault}, 32'h0);

      wr(CYC_LO, 32'h1);
      chk("cyc_write_fault", {31'h0, fault}, 32'h1);
      chk("cyc_write_fault_addr", fault_addr, CYC_LO);

      wr(SCRATCH, 32'h1234);
      wr(TOHOST, 32'hDEAD);
      wr(32'h0, 32'd5);
      chk("halted", {31'h0, halted}, 32'h1);
      chk("halt_code", halt_code, 32'hDEAD);
      rd(TOHOST, 32'hDEAD, "tohost_read");
      rd(SCRATCH, 32'h1234, "scratch_read");
      rd(32'h0, 32'd10, "halt_blocks_ram");
      wr(TOHOST, 32'hBEEF);
      chk("halt_code_locked", halt_code, 32'hDEAD);

`ifdef DMEM_CYCLE_COUNTER_EN
      frozen = cyc_m[31:0];
`else
      frozen = 32'h0;
`endif
      rd(CYC_LO, frozen, "cycle_frozen_a");
      repeat (5) @(posedge clk);
      rd(CYC_LO, frozen, "cycle_frozen_b");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
